// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register bank.
//   i2c_tgt_state_t : protocol FSM states
//   ACK / NACK      : SDA level of the acknowledge bit
//   RW_BIT          : position of the R/W flag inside the address byte
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdataAck,
        StIgnore
    } i2c_tgt_state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int unsigned RW_BIT = 0;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser plus a history stage for one asynchronous pad input.
//   clk, rst_n : system clock, async active-low reset (flops reset to 1 = bus idle)
//   d_i        : asynchronous pad level
//   level_o    : synchronised level, aligned with the edge pulses
//   rise_o     : one-cycle pulse on a 0->1 transition
//   fall_o     : one-cycle pulse on a 1->0 transition
// Pad edge to pulse is 3 clk: two synchroniser flops, then the history/pulse stage.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, hist_q, rise_q, fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            hist_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            hist_q <= s2_q;
            rise_q <= s2_q & ~hist_q;
            fall_q <= ~s2_q & hist_q;
        end
    end

    assign level_o = hist_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register bank and auto-incrementing pointer.
//   scl_i, sda_i     : asynchronous pad inputs
//   sda_oe           : 1 pulls SDA low (open drain)
//   loc_addr/rdata   : combinational local read port into the bank
//   wr_strobe/addr/data : one-cycle report of every committed I2C data byte
//   busy             : addressed transaction in progress
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h42,
    parameter int unsigned NUM_REGS = 16,
    localparam int unsigned PW      = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    input  logic [PW-1:0] loc_addr,
    output logic [7:0]    loc_rdata,
    output logic          wr_strobe,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    localparam logic [PW-1:0] PtrOne = PW'(1);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .d_i     (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    i2c_tgt_state_t state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic           sda_oe_q, sda_oe_d;
    logic           busy_q, busy_d;
    logic           rw_q, rw_d;
    logic           wr_strobe_q, wr_strobe_d;
    logic [PW-1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]     wr_data_q, wr_data_d;
    logic [7:0]     regs_q [NUM_REGS];

    logic          start_det, stop_det;
    logic [7:0]    rx_byte;
    logic [PW-1:0] ptr_inc;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign rx_byte   = {shift_q[6:0], sda_lvl};
    assign ptr_inc   = ptr_q + PtrOne;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        rw_d        = rw_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;

        // START/STOP override everything; a partial byte is simply dropped.
        if (start_det) begin
            state_d   = StAddr;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = StIdle;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                StAddr, StPtr, StWdata: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == StAddr) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state_d = StAddrAck;
                                    rw_d    = rx_byte[RW_BIT];
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = StIgnore;
                                    busy_d  = 1'b0;
                                end
                            end else if (state_q == StPtr) begin
                                ptr_d   = rx_byte[PW-1:0];
                                state_d = StPtrAck;
                            end else begin
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = ptr_q;
                                wr_data_d   = rx_byte;
                                ptr_d       = ptr_inc;
                                state_d     = StWdataAck;
                            end
                        end
                    end
                end
                // First SCL fall drives the ACK, the second releases it.
                StAddrAck, StPtrAck, StWdataAck: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            if (state_q == StAddrAck && rw_q) begin
                                // Present the first read bit on this same falling edge.
                                state_d  = StRdata;
                                shift_d  = regs_q[ptr_q];
                                sda_oe_d = ~regs_q[ptr_q][7];
                            end else if (state_q == StAddrAck) begin
                                state_d = StPtr;
                            end else begin
                                state_d = StWdata;
                            end
                        end
                    end
                end
                StRdata: begin
                    if (scl_fall) begin
                        sda_oe_d = ~shift_q[7];
                    end
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = StRdataAck;
                        end
                    end
                end
                StRdataAck: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                    end
                    if (scl_rise) begin
                        if (sda_lvl == ACK) begin
                            ptr_d   = ptr_inc;
                            shift_d = regs_q[ptr_inc];
                            state_d = StRdata;
                        end else begin
                            state_d = StIgnore;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_strobe_d) begin
            regs_q[wr_addr_d] <= wr_data_d;
        end
    end

    assign sda_oe    = sda_oe_q;
    assign loc_rdata = regs_q[loc_addr];
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: a bit-banged I2C master on an open-drain SDA line.
module tb_i2c_target_regs;
    import i2c_pkg::*;

    localparam int Q = 5;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic [3:0] loc_addr = 4'd0;
    logic [7:0] loc_rdata;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    int n_pass = 0;
    int n_total = 0;

    logic [3:0] q_addr[$];
    logic [7:0] q_data[$];
    logic       oe_seen = 1'b0;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_regs #(
        .DEV_ADDR (7'h42),
        .NUM_REGS (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_oe    (sda_oe),
        .loc_addr  (loc_addr),
        .loc_rdata (loc_rdata),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            q_addr.push_back(wr_addr);
            q_data.push_back(wr_data);
        end
        if (sda_oe === 1'b1) oe_seen = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        ack = sda_line; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wait_q();
            scl_m = 1'b1; wait_q();
            d[i] = sda_line; wait_q();
            scl_m = 1'b0; wait_q();
        end
        send_bit(mack);
    endtask

    task automatic test_reset();
        n_total++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe got %b want 0", sda_oe);
        else n_pass++;
        n_total++; if (wr_strobe !== 1'b0) $display("FAIL reset_wr_strobe got %b want 0", wr_strobe);
        else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
        else n_pass++;
        loc_addr = 4'd7; #1;
        n_total++; if (loc_rdata !== 8'h00) $display("FAIL reset_reg7 got %h want 00", loc_rdata);
        else n_pass++;
        n_total++;
        if (dut.state_q !== StIdle) $display("FAIL reset_state got %0d want StIdle", dut.state_q);
        else n_pass++;
    endtask

    task automatic test_write();
        logic a0, a1, a2, a3;
        q_addr.delete(); q_data.delete();
        bus_start();
        send_byte(8'h84, a0);
        n_total++; if (busy !== 1'b1) $display("FAIL write_busy got %b want 1", busy);
        else n_pass++;
        send_byte(8'h03, a1);
        send_byte(8'hA5, a2);
        send_byte(8'h5A, a3);
        bus_stop();
        n_total++;
        if ({a0, a1, a2, a3} !== 4'b0000) $display("FAIL write_acks got %b want 0000", {a0, a1, a2, a3});
        else n_pass++;
        n_total++;
        if (q_addr.size() != 2) $display("FAIL write_strobes got %0d want 2", q_addr.size());
        else begin
            if (q_addr[0] === 4'd3 && q_data[0] === 8'hA5 && q_addr[1] === 4'd4 && q_data[1] === 8'h5A)
                n_pass++;
            else $display("FAIL write_strobes got %h:%h %h:%h want 3:a5 4:5a",
                          q_addr[0], q_data[0], q_addr[1], q_data[1]);
        end
        loc_addr = 4'd4; #1;
        n_total++; if (loc_rdata !== 8'h5A) $display("FAIL write_reg4 got %h want 5a", loc_rdata);
        else n_pass++;
        loc_addr = 4'd3; #1;
        n_total++; if (loc_rdata !== 8'hA5) $display("FAIL write_reg3 got %h want a5", loc_rdata);
        else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL write_busy_end got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_read_sr();
        logic       a;
        logic [7:0] d0, d1;
        q_addr.delete(); q_data.delete();
        // Seed regs[15] and regs[0]; the second byte lands at 0 through pointer wrap.
        bus_start();
        send_byte(8'h84, a); send_byte(8'h0F, a); send_byte(8'h3C, a); send_byte(8'hC3, a);
        bus_stop();
        n_total++;
        if (q_addr.size() != 2 || q_addr[1] !== 4'd0)
            $display("FAIL wrap_write got n=%0d addr=%h want n=2 addr=0", q_addr.size(),
                     (q_addr.size() > 1) ? q_addr[1] : 4'hx);
        else n_pass++;
        bus_start();
        send_byte(8'h84, a); send_byte(8'h0F, a);
        bus_start();
        send_byte(8'h85, a);
        n_total++; if (a !== ACK) $display("FAIL read_addr_ack got %b want 0", a);
        else n_pass++;
        read_byte(ACK, d0);
        read_byte(NACK, d1);
        bus_stop();
        n_total++; if (d0 !== 8'h3C) $display("FAIL read_byte0 got %h want 3c", d0);
        else n_pass++;
        n_total++; if (d1 !== 8'hC3) $display("FAIL read_byte1 got %h want c3", d1);
        else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL read_busy_end got %b want 0", busy);
        else n_pass++;
    endtask

    task automatic test_mismatch();
        logic a0, a1;
        q_addr.delete(); q_data.delete();
        oe_seen = 1'b0;
        bus_start();
        send_byte(8'h86, a0);
        n_total++; if (busy !== 1'b0) $display("FAIL mismatch_busy got %b want 0", busy);
        else n_pass++;
        send_byte(8'hFF, a1);
        bus_stop();
        n_total++; if ({a0, a1} !== 2'b11) $display("FAIL mismatch_nack got %b want 11", {a0, a1});
        else n_pass++;
        n_total++; if (oe_seen !== 1'b0) $display("FAIL mismatch_oe got %b want 0", oe_seen);
        else n_pass++;
        n_total++; if (q_addr.size() != 0) $display("FAIL mismatch_strobe got %0d want 0", q_addr.size());
        else n_pass++;
    endtask

    task automatic test_abort();
        logic a;
        bus_start();
        send_byte(8'h84, a); send_byte(8'h05, a); send_byte(8'h11, a);
        bus_stop();
        q_addr.delete(); q_data.delete();
        bus_start();
        send_byte(8'h84, a); send_byte(8'h05, a);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        bus_stop();
        n_total++; if (q_addr.size() != 0) $display("FAIL abort_strobe got %0d want 0", q_addr.size());
        else n_pass++;
        loc_addr = 4'd5; #1;
        n_total++; if (loc_rdata !== 8'h11) $display("FAIL abort_reg5 got %h want 11", loc_rdata);
        else n_pass++;
        n_total++;
        if (dut.state_q !== StIdle) $display("FAIL abort_state got %0d want StIdle", dut.state_q);
        else n_pass++;
    endtask

    task automatic test_ack_timing();
        logic [7:0] b;
        int         cnt;
        b = 8'h84;
        cnt = 0;
        bus_start();
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        sda_m = b[0]; wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (cnt == 0 && sda_oe === 1'b1) cnt = i;
        end
        n_total++; if (cnt != 4) $display("FAIL ack_latency got %0d clk want 4", cnt);
        else n_pass++;
        @(negedge clk);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
        bus_stop();
    endtask

    task automatic test_reset_mid_read();
        logic a;
        bus_start();
        send_byte(8'h84, a); send_byte(8'h0F, a);
        bus_start();
        send_byte(8'h85, a);
        // regs[15] = 0x3C, so its MSB (0) is being driven low now.
        n_total++; if (sda_oe !== 1'b1) $display("FAIL midread_oe got %b want 1", sda_oe);
        else n_pass++;
        rst_n = 1'b0; #1;
        n_total++; if (sda_oe !== 1'b0) $display("FAIL reset_async_oe got %b want 0", sda_oe);
        else n_pass++;
        scl_m = 1'b1; sda_m = 1'b1;
        for (int i = 0; i < 16; i++) begin
            loc_addr = 4'(i); #1;
            n_total++;
            if (loc_rdata !== 8'h00) $display("FAIL reset_reg%0d got %h want 00", i, loc_rdata);
            else n_pass++;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy_after got %b want 0", busy);
        else n_pass++;
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        test_reset();
        test_write();
        test_read_sr();
        test_mismatch();
        test_abort();
        test_ack_timing();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
